// File: rtl/timer_cmp_if.sv
// Bundle between the counter stage / register file and the compare-and-interrupt block.
// The master side drives count, compare value, enables and W1C strobes; the slave returns status.
interface timer_cmp_if #(
  parameter int CNT_W = 64
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp_val;
  logic             timer_en;
  logic             cnt_load;
  logic             int_en;
  logic             ovf_en;
  logic             int_clr;
  logic             ovf_clr;
  logic             int_st;
  logic             ovf_st;
  logic             tim_int;

  modport master (
    output cnt, cmp_val, timer_en, cnt_load, int_en, ovf_en, int_clr, ovf_clr,
    input  int_st, ovf_st, tim_int
  );

  modport slave (
    input  cnt, cmp_val, timer_en, cnt_load, int_en, ovf_en, int_clr, ovf_clr,
    output int_st, ovf_st, tim_int
  );
endinterface

// File: rtl/timer_cmp_irq.sv
// Compare-match and overflow detection on the free-running timer count, with
// W1C status flags and a registered, enable-gated level interrupt.
module timer_cmp_irq #(
  parameter int CNT_W = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  timer_cmp_if.slave  bus
);

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_load_q;
  logic             match_q;
  logic             int_st_q;
  logic             ovf_st_q;
  logic             tim_int_q;

  logic             match_d;
  logic             match_evt_s;
  logic             ovf_evt_s;
  logic             int_st_d;
  logic             ovf_st_d;
  logic             tim_int_d;

  // Event detection and next-state for flags and interrupt line
  always_comb begin
    match_d     = bus.timer_en & (bus.cnt == bus.cmp_val);
    match_evt_s = match_d & ~match_q;
    // A wrap caused by a TDR load is not an overflow, hence the delayed load qualifier.
    ovf_evt_s   = bus.timer_en & (cnt_q == {CNT_W{1'b1}}) &
                  (bus.cnt == {CNT_W{1'b0}}) & ~cnt_load_q;

    if (match_evt_s) begin
      int_st_d = 1'b1;
    end else if (bus.int_clr) begin
      int_st_d = 1'b0;
    end else begin
      int_st_d = int_st_q;
    end

    if (ovf_evt_s) begin
      ovf_st_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_st_d = 1'b0;
    end else begin
      ovf_st_d = ovf_st_q;
    end

    tim_int_d = (int_st_q & bus.int_en) | (ovf_st_q & bus.ovf_en);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= {CNT_W{1'b0}};
      cnt_load_q <= 1'b0;
      match_q    <= 1'b0;
      int_st_q   <= 1'b0;
      ovf_st_q   <= 1'b0;
      tim_int_q  <= 1'b0;
    end else begin
      cnt_q      <= bus.cnt;
      cnt_load_q <= bus.cnt_load;
      match_q    <= match_d;
      int_st_q   <= int_st_d;
      ovf_st_q   <= ovf_st_d;
      tim_int_q  <= tim_int_d;
    end
  end

  assign bus.int_st  = int_st_q;
  assign bus.ovf_st  = ovf_st_q;
  assign bus.tim_int = tim_int_q;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Scoreboard bench for timer_cmp_irq: expected flags are queued when inputs are
// applied and compared after the clock edge, plus directed checks at key points.
module tb_timer_cmp_irq;
  localparam int CNT_W = 64;
  localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  timer_cmp_if #(.CNT_W(CNT_W)) bus ();

  timer_cmp_irq #(.CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic i;
    logic o;
    logic t;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic             m_int, m_ovf, m_tim, m_prev_match, m_prev_load;
  logic [CNT_W-1:0] m_prev_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_int = 1'b0; m_ovf = 1'b0; m_tim = 1'b0;
    m_prev_match = 1'b0; m_prev_load = 1'b0; m_prev_cnt = '0;
    sb_q.delete();
  endtask

  // Apply current inputs for one clock; push the expected result, then pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t got;
    logic match_now, match_rise, wrap;
    match_now  = bus.timer_en && (bus.cnt == bus.cmp_val);
    match_rise = match_now && !m_prev_match;
    wrap       = bus.timer_en && (m_prev_cnt == ALL1) && (bus.cnt == '0) && !m_prev_load;
    e.t = (m_int && bus.int_en) || (m_ovf && bus.ovf_en);
    e.i = match_rise ? 1'b1 : (bus.int_clr ? 1'b0 : m_int);
    e.o = wrap ? 1'b1 : (bus.ovf_clr ? 1'b0 : m_ovf);
    sb_q.push_back(e);
    m_int = e.i; m_ovf = e.o; m_tim = e.t;
    m_prev_match = match_now; m_prev_cnt = bus.cnt; m_prev_load = bus.cnt_load;
    @(posedge sys_clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check_eq({tag, "_int_st"},  {63'd0, bus.int_st},  {63'd0, got.i});
      check_eq({tag, "_ovf_st"},  {63'd0, bus.ovf_st},  {63'd0, got.o});
      check_eq({tag, "_tim_int"}, {63'd0, bus.tim_int}, {63'd0, got.t});
    end
  endtask

  task automatic chk_out(input string tag, input logic i, input logic o, input logic t);
    check_eq({tag, "_int_st"},  {63'd0, bus.int_st},  {63'd0, i});
    check_eq({tag, "_ovf_st"},  {63'd0, bus.ovf_st},  {63'd0, o});
    check_eq({tag, "_tim_int"}, {63'd0, bus.tim_int}, {63'd0, t});
  endtask

  initial begin
    logic [CNT_W-1:0] rc;
    sys_rst_n    = 1'b0;
    bus.cnt      = '0;
    bus.cmp_val  = '0;
    bus.timer_en = 1'b0;
    bus.cnt_load = 1'b0;
    bus.int_en   = 1'b0;
    bus.ovf_en   = 1'b0;
    bus.int_clr  = 1'b0;
    bus.ovf_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;

    // T1: count 0..20 against compare 10
    bus.cmp_val = 64'd10; bus.int_en = 1'b1; bus.timer_en = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      bus.cnt = CNT_W'(c);
      cycle("t1");
      if (c == 10) chk_out("t1_set", 1'b1, 1'b0, 1'b0);
      if (c == 11) chk_out("t1_irq", 1'b1, 1'b0, 1'b1);
    end
    bus.int_clr = 1'b1; cycle("t1_clr"); bus.int_clr = 1'b0;

    // T2: halted on the compare value; one event, clear sticks
    bus.cnt = 64'd10;
    for (int i = 0; i < 50; i++) begin
      bus.int_clr = (i == 5);
      cycle("t2");
      if (i == 2) chk_out("t2_once", 1'b1, 1'b0, 1'b1);
    end
    bus.int_clr = 1'b0;
    chk_out("t2_held", 1'b0, 1'b0, 1'b0);

    // T3: clear collides with a new match edge; set wins
    bus.cnt = 64'd11; cycle("t3");
    bus.cnt = 64'd10; cycle("t3");
    bus.cnt = 64'd11; cycle("t3");
    bus.cnt = 64'd10; bus.int_clr = 1'b1; cycle("t3_coll");
    bus.int_clr = 1'b0;
    chk_out("t3_setwins", 1'b1, 1'b0, 1'b1);
    bus.int_clr = 1'b1; bus.int_en = 1'b0; cycle("t3_clr"); bus.int_clr = 1'b0;

    // T4: natural wrap sets overflow, TDR-load wrap does not
    bus.cmp_val = 64'd5; bus.ovf_en = 1'b1;
    bus.cnt = ALL1 - 64'd1; cycle("t4");
    bus.cnt = ALL1;         cycle("t4");
    bus.cnt = 64'd0;        cycle("t4");
    chk_out("t4_ovf", 1'b0, 1'b1, 1'b0);
    bus.cnt = 64'd1;        cycle("t4");
    chk_out("t4_irq", 1'b0, 1'b1, 1'b1);
    bus.ovf_clr = 1'b1; cycle("t4_clr"); bus.ovf_clr = 1'b0;
    bus.cnt = ALL1; bus.cnt_load = 1'b1; cycle("t4_ld");
    bus.cnt = 64'd0; bus.cnt_load = 1'b0; cycle("t4_ld");
    bus.cnt = 64'd1; cycle("t4_ld");
    chk_out("t4_noovf", 1'b0, 1'b0, 1'b0);

    // T5: status sets with interrupt disabled, enabling later raises the line
    bus.ovf_en = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      bus.cnt = CNT_W'(c);
      cycle("t5");
    end
    chk_out("t5_masked", 1'b1, 1'b0, 1'b0);
    bus.int_en = 1'b1; cycle("t5_en");
    chk_out("t5_unmask", 1'b1, 1'b0, 1'b1);

    // timer_en low: no match, flags hold; re-enable on match fires anew
    bus.int_clr = 1'b1; cycle("dis_clr"); bus.int_clr = 1'b0;
    bus.timer_en = 1'b0; bus.cnt = 64'd5;
    repeat (3) cycle("dis");
    chk_out("dis_nomatch", 1'b0, 1'b0, 1'b0);
    bus.timer_en = 1'b1; cycle("reen");
    chk_out("reen_match", 1'b1, 1'b0, 1'b0);
    cycle("reen");

    // T6: asynchronous reset mid-operation
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cycle("t6_rel");
    chk_out("t6_refire", 1'b1, 1'b0, 1'b0);

    // Random mix near the wrap point and the compare value
    bus.cmp_val = ALL1 - 64'd2;
    bus.cnt = ALL1 - 64'd6;
    for (int i = 0; i < 400; i++) begin
      rc = bus.cnt + 64'd1;
      case ($urandom_range(0, 9))
        0:       rc = bus.cnt;
        1:       rc = ALL1;
        2:       rc = bus.cmp_val;
        3:       rc = ALL1 - 64'($urandom_range(0, 8));
        default: rc = bus.cnt + 64'd1;
      endcase
      bus.cnt      = rc;
      bus.cnt_load = ($urandom_range(0, 7) == 0);
      bus.timer_en = ($urandom_range(0, 9) != 0);
      bus.int_en   = ($urandom_range(0, 3) != 0);
      bus.ovf_en   = ($urandom_range(0, 3) != 0);
      bus.int_clr  = ($urandom_range(0, 5) == 0);
      bus.ovf_clr  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) bus.cmp_val = 64'($urandom_range(0, 3));
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
